alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator for the 8-bit three-operand ALU: accepts instructions over valid/ready, reads operands
//  from a small register file, drives the ALU's a/b/s/n/ci inputs, captures w and the flags, and
//  writes the result back. It sits between the instruction source and the combinational ALU.
//  It owns the architectural register file and the C/V/Z/N flag register.
// PARAMETERS
//  NREGS    8    register-file depth (power of 2, >=2); AW = $clog2(NREGS)
//  CNT_W    16   width of the retired-op counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  instr_valid  in   1      instruction offered
//  instr_ready  out  1      sequencer can accept an instruction (high only in IDLE)
//  instr_op     in   3      ALU select s (0..7)
//  instr_rd     in   AW     destination register
//  instr_ra     in   AW     operand-A register
//  instr_rb     in   AW     operand-B register
//  instr_n      in   3      shift amount for ops 3/4
//  instr_useci  in   1      1: ci = stored C flag; 0: ci = 0
//  ld_en        in   1      host register write strobe
//  ld_addr      in   AW     host write address
//  ld_data      in   8      host write data
//  rd_addr      in   AW     host read address
//  rd_data      out  8      combinational read of regfile[rd_addr]
//  alu_a/alu_b  out  8      ALU operands (signed)
//  alu_s        out  3      ALU select
//  alu_n        out  3      ALU shift amount
//  alu_ci       out  1      ALU carry-in
//  alu_w        in   8      ALU result
//  alu_co/alu_ov/alu_z/alu_neg in 1   ALU flags
//  flags        out  4      {C,V,Z,N} registered
//  done         out  1      one-cycle pulse on the writeback edge
//  op_count     out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all registers, flags, alu_* outputs, done, op_count = 0;
//    instr_ready = 1 as soon as rst_n deasserts. Reset mid-instruction aborts it; no writeback.
//  - States: IDLE -(instr_valid&instr_ready)-> READ -> EXEC -> WB -> IDLE. No other transitions.
//  - IDLE: latch op, rd, ra, rb, n, useci on the handshake edge.
//  - READ: register regfile[ra], regfile[rb] into alu_a/alu_b; alu_s, alu_n driven from latch;
//    alu_ci = useci & C.
//  - EXEC: alu_* held stable; ALU settles combinationally; capture alu_w and flags into holding regs.
//  - WB: regfile[rd] <= captured w; flags <= {co,ov,z,neg}; done=1; op_count += 1 (mod 2^CNT_W).
//  - Latency: handshake edge at cycle 0, writeback edge at cycle 3; next accept at cycle 4 earliest.
//  - All flags update on every op; C takes alu_co as given (ALU returns 0 for ops without carry).
//  - ra, rb or rd may alias; operands are sampled in READ, so rd==ra is safe.
//  - ld_en is accepted in any state, applied on its edge. ld_en to rd on the WB edge: WB wins.
//    ld_en to ra/rb on the READ edge: old value is read.
//  - rd_data reflects writes from the edge after they occur (no bypass).
//  - instr_valid while not ready: instruction ignored, held by source; no buffering.
//  - alu_* outputs hold their last values in IDLE.
// STRUCTURE
//  - Shared package alu_pkg: typedef enum logic[2:0] alu_op_e (ADDC=0, ADD=1, MAX=2, SHLADD=3,
//    SARADD=4, ABS=5, ADD2B=6, AND=7); typedef enum seq_state_e {IDLE,READ,EXEC,WB};
//    flag index constants F_C=3, F_V=2, F_Z=1, F_N=0.
//  - One sub-module: seq_regfile (NREGS x 8, two async read ports plus host read,
//    one write port with WB-over-ld priority mux).
//  - ALU instantiated outside; the bench connects the real ALU to alu_* ports.
// TESTING
//  1 reset: drive rst_n=0 mid-EXEC -> flags=0, op_count=0, regfile all 0x00, no done pulse.
//  2 ld R1=0x7F, R2=0x01; op=1 rd=R3 -> R3=0x80, flags C=0 V=1 Z=0 N=1, done at cycle 3.
//  3 ld R1=0xFF, R2=0x01; op=1 rd=R4 -> R4=0x00, C=1 Z=1; then op=0 useci=1 on R0,R0 -> 0x01.
//  4 ld R5=0x80; op=5 ra=R5 -> 0x80, N=1. ld R5=0xF6; op=5 -> 0x0A.
//  5 ld R1=0x10, R2=0x20; op=6 -> 0x50. op=3 ra=R1 n=2 -> 0x50. op=2 with 0xF0, 0x05 -> 0x05.
//  6 instr_valid held through busy -> only one accept per 4 cycles; 65536 ops -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_pkg;

   // ALU select encodings as understood by the external combinational ALU.
   typedef enum logic [2:0] {
      ADDC   = 3'd0,
      ADD    = 3'd1,
      MAX    = 3'd2,
      SHLADD = 3'd3,
      SARADD = 3'd4,
      ABS    = 3'd5,
      ADD2B  = 3'd6,
      AND    = 3'd7
   } alu_op_e;

   // Sequencer phases; one instruction walks IDLE -> READ -> EXEC -> WB -> IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } seq_state_e;

   // Bit positions inside the {C,V,Z,N} flag word.
   localparam int F_C = 3;
   localparam int F_V = 2;
   localparam int F_Z = 1;
   localparam int F_N = 0;

   // Place individual ALU flags at their architectural positions.
   function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                             input logic z, input logic n);
      logic [3:0] f;
      f      = '0;
      f[F_C] = c;
      f[F_V] = v;
      f[F_Z] = z;
      f[F_N] = n;
      return f;
   endfunction

endpackage

// File: rtl/seq_regfile.sv
// Architectural register file: NREGS x 8, two operand read ports, one host
// read port, one write port shared between writeback and host loads.
module seq_regfile
   import alu_pkg::*;
#(
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra_addr,
   output logic [7:0]    ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [7:0]    rb_data,
   input  logic [AW-1:0] host_addr,
   output logic [7:0]    host_data,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [7:0]    wb_data,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_data
);

   logic [7:0] mem_q [NREGS];
   logic [7:0] mem_d [NREGS];

   // Asynchronous reads; no write bypass, so writes show up after their edge.
   always_comb begin
      ra_data   = mem_q[ra_addr];
      rb_data   = mem_q[rb_addr];
      host_data = mem_q[host_addr];
   end

   // Next contents: host load applied first so a same-edge writeback overrides it.
   always_comb begin
      mem_d = mem_q;
      if (ld_en) begin
         mem_d[ld_addr] = ld_data;
      end
      if (wb_en) begin
         mem_d[wb_addr] = wb_data;
      end
   end

   // Storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the external 8-bit three-operand ALU. Reads
// operands from its register file, drives the ALU, captures the result and
// flags, and writes them back four cycles per instruction.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE and does not
// depend on instr_valid; the source must hold the instruction stable until
// it transfers. Nothing is buffered.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter  int NREGS = 8,
   parameter  int CNT_W = 16,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_ra,
   input  logic [AW-1:0]    instr_rb,
   input  logic [2:0]       instr_n,
   input  logic             instr_useci,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [7:0]       ld_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [7:0]       rd_data,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_s,
   output logic [2:0]       alu_n,
   output logic             alu_ci,
   input  logic [7:0]       alu_w,
   input  logic             alu_co,
   input  logic             alu_ov,
   input  logic             alu_z,
   input  logic             alu_neg,
   output logic [3:0]       flags,
   output logic             done,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_READ = READ;
   localparam logic [1:0] S_EXEC = EXEC;
   localparam logic [1:0] S_WB   = WB;

   logic [1:0]       state_q,    state_d;
   logic [2:0]       op_q,       op_d;
   logic [AW-1:0]    rd_q,       rd_d;
   logic [AW-1:0]    ra_q,       ra_d;
   logic [AW-1:0]    rb_q,       rb_d;
   logic [2:0]       n_q,        n_d;
   logic             useci_q,    useci_d;
   logic [7:0]       alu_a_q,    alu_a_d;
   logic [7:0]       alu_b_q,    alu_b_d;
   logic [2:0]       alu_s_q,    alu_s_d;
   logic [2:0]       alu_n_q,    alu_n_d;
   logic             alu_ci_q,   alu_ci_d;
   logic [7:0]       w_hold_q,   w_hold_d;
   logic [3:0]       fl_hold_q,  fl_hold_d;
   logic [3:0]       flags_q,    flags_d;
   logic             done_q,     done_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             accept;
   logic             wb_en;
   logic [7:0]       ra_data;
   logic [7:0]       rb_data;

   seq_regfile #(.NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_addr   (ra_q),
      .ra_data   (ra_data),
      .rb_addr   (rb_q),
      .rb_data   (rb_data),
      .host_addr (rd_addr),
      .host_data (rd_data),
      .wb_en     (wb_en),
      .wb_addr   (rd_q),
      .wb_data   (w_hold_q),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   assign instr_ready = (state_q == S_IDLE);
   assign accept      = instr_valid & instr_ready;
   assign wb_en       = (state_q == S_WB);

   // Phase sequencing: latch on accept, drive ALU in READ, capture in EXEC, retire in WB.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd_d       = rd_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      n_d        = n_q;
      useci_d    = useci_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_s_d    = alu_s_q;
      alu_n_d    = alu_n_q;
      alu_ci_d   = alu_ci_q;
      w_hold_d   = w_hold_q;
      fl_hold_d  = fl_hold_q;
      flags_d    = flags_q;
      done_d     = 1'b0;
      op_count_d = op_count_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = instr_op;
               rd_d    = instr_rd;
               ra_d    = instr_ra;
               rb_d    = instr_rb;
               n_d     = instr_n;
               useci_d = instr_useci;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // Operands sampled here, so a load landing on this edge is not seen.
            alu_a_d  = ra_data;
            alu_b_d  = rb_data;
            alu_s_d  = op_q;
            alu_n_d  = n_q;
            alu_ci_d = useci_q & flags_q[F_C];
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            w_hold_d  = alu_w;
            fl_hold_d = pack_flags(alu_co, alu_ov, alu_z, alu_neg);
            state_d   = S_WB;
         end
         S_WB: begin
            flags_d    = fl_hold_q;
            done_d     = 1'b1;
            op_count_d = op_count_q + CNT_W'(1);
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state, instruction latch, ALU drive and retirement registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         rd_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         n_q        <= '0;
         useci_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_s_q    <= '0;
         alu_n_q    <= '0;
         alu_ci_q   <= 1'b0;
         w_hold_q   <= '0;
         fl_hold_q  <= '0;
         flags_q    <= '0;
         done_q     <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         n_q        <= n_d;
         useci_q    <= useci_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_s_q    <= alu_s_d;
         alu_n_q    <= alu_n_d;
         alu_ci_q   <= alu_ci_d;
         w_hold_q   <= w_hold_d;
         fl_hold_q  <= fl_hold_d;
         flags_q    <= flags_d;
         done_q     <= done_d;
         op_count_q <= op_count_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_s     = alu_s_q;
   assign alu_n     = alu_n_q;
   assign alu_ci    = alu_ci_q;
   assign flags     = flags_q;
   assign done      = done_q;
   assign op_count  = op_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the alu_* ports, a
// register/flag reference model, and a done-driven scoreboard.
module tb_alu_op_sequencer;

   localparam int NREGS = 8;
   localparam int AW    = 3;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             instr_valid = 1'b0;
   logic             instr_ready;
   logic [2:0]       instr_op = '0;
   logic [AW-1:0]    instr_rd = '0;
   logic [AW-1:0]    instr_ra = '0;
   logic [AW-1:0]    instr_rb = '0;
   logic [2:0]       instr_n = '0;
   logic             instr_useci = 1'b0;
   logic             ld_en = 1'b0;
   logic [AW-1:0]    ld_addr = '0;
   logic [7:0]       ld_data = '0;
   logic [AW-1:0]    rd_addr;
   logic [7:0]       rd_data;
   logic [7:0]       alu_a, alu_b;
   logic [2:0]       alu_s, alu_n;
   logic             alu_ci;
   logic [7:0]       alu_w;
   logic             alu_co, alu_ov, alu_z, alu_neg;
   logic [3:0]       flags;
   logic             done;
   logic [CNT_W-1:0] op_count;
   logic [1:0]       dbg_state;

   logic [AW-1:0]    drv_addr = '0;
   logic [AW-1:0]    mon_addr = '0;
   logic             dump_mode = 1'b0;
   assign rd_addr = dump_mode ? drv_addr : mon_addr;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct packed {
      logic [AW-1:0]    rd;
      logic [7:0]       w;
      logic [3:0]       fl;
      logic [CNT_W-1:0] cnt;
      logic [31:0]      cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [7:0] m_regs [NREGS];
   logic [3:0] m_flags = '0;
   int         m_count = 0;

   alu_op_sequencer #(.NREGS(NREGS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
      .instr_rb(instr_rb), .instr_n(instr_n), .instr_useci(instr_useci),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_n(alu_n), .alu_ci(alu_ci),
      .alu_w(alu_w), .alu_co(alu_co), .alu_ov(alu_ov), .alu_z(alu_z), .alu_neg(alu_neg),
      .flags(flags), .done(done), .op_count(op_count), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural ALU ----------------
   // {sum, carry, signed overflow} of x + y + c
   function automatic logic [9:0] add8(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] u;
      int r;
      u = {1'b0, x} + {1'b0, y} + {8'd0, c};
      r = int'($signed(x)) + int'($signed(y)) + int'(c);
      return {u[7:0], u[8], (r > 127 || r < -128)};
   endfunction

   // Returns {w, C, V, Z, N}
   function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s, input logic [2:0] n,
                                           input logic ci);
      logic [9:0] r;
      logic [7:0] t;
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (s)
         3'd0: r = add8(a, b, ci);
         3'd1: r = add8(a, b, 1'b0);
         3'd2: r = {(sa > sb) ? a : b, 2'b00};
         3'd3: begin t = a << n; r = add8(t, b, 1'b0); end
         3'd4: begin t = $signed(a) >>> n; r = add8(t, b, 1'b0); end
         3'd5: r = {(sa < 0) ? 8'(-sa) : a, 1'b0, (a == 8'h80)};
         3'd6: begin t = b << 1; r = add8(a, t, 1'b0); end
         default: r = {a & b, 2'b00};
      endcase
      return {r[9:2], r[1], r[0], (r[9:2] == 8'h00), r[9]};
   endfunction

   always_comb {alu_w, alu_co, alu_ov, alu_z, alu_neg} = alu_ref(alu_a, alu_b, alu_s, alu_n, alu_ci);

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      m_flags = '0;
      m_count = 0;
   endtask

   // Execute one instruction on the model and queue what retirement must show.
   task automatic model_push(input logic [2:0] op, input logic [AW-1:0] rd,
                             input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [2:0] n, input logic uc, input int c);
      logic [11:0] r;
      exp_t e;
      r = alu_ref(m_regs[ra], m_regs[rb], op, n, uc & m_flags[3]);
      m_regs[rd] = r[11:4];
      m_flags    = r[3:0];
      m_count    = (m_count + 1) % (1 << CNT_W);
      e.rd  = rd;
      e.w   = r[11:4];
      e.fl  = r[3:0];
      e.cnt = CNT_W'(m_count);
      e.cyc = 32'(c);
      exp_q.push_back(e);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_flags", 32'(flags), 32'(mon_e.fl));
            check("wb_count", 32'(op_count), 32'(mon_e.cnt));
            check("wb_latency", 32'(cyc), mon_e.cyc + 32'd3);
            mon_addr = mon_e.rd;
            #1;
            check("wb_data", 32'(rd_data), 32'(mon_e.w));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic ld(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      m_regs[a] = d;
   endtask

   // Returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [2:0] n, input logic uc);
      int w;
      w = 0;
      @(negedge clk);
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) begin
         checks++; failures++;
         $display("FAIL issue_ready_timeout actual=not_ready required=ready");
         return;
      end
      instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
      instr_n = n; instr_useci = uc; instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      model_push(op, rd, ra, rb, n, uc, cyc);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL wait_done_timeout actual=pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic host_read(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
      @(negedge clk);
      drv_addr = a; dump_mode = 1'b1;
      #1;
      check(name, 32'(rd_data), 32'(exp));
      dump_mode = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      logic rdy;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);

      // 0x7F + 0x01 overflows into the sign bit
      ld(1, 8'h7F); ld(2, 8'h01);
      issue(3'd1, 3, 1, 2, 0, 1'b0);
      wait_idle();
      host_read("t2_r3", 3, 8'h80);
      check("t2_flags", 32'(flags), 32'b0101);

      // Carry out, then ADDC consumes it on zero operands
      ld(1, 8'hFF); ld(2, 8'h01);
      issue(3'd1, 4, 1, 2, 0, 1'b0);
      wait_idle();
      host_read("t3_r4", 4, 8'h00);
      check("t3_flags", 32'(flags), 32'b1010);
      issue(3'd0, 6, 0, 0, 0, 1'b1);
      wait_idle();
      host_read("t3_addc", 6, 8'h01);

      // ABS at the negative limit and an ordinary negative
      ld(5, 8'h80);
      issue(3'd5, 7, 5, 5, 0, 1'b0);
      wait_idle();
      host_read("t4_abs80", 7, 8'h80);
      check("t4_nflag", 32'(flags[0]), 32'd1);
      ld(5, 8'hF6);
      issue(3'd5, 7, 5, 5, 0, 1'b0);
      wait_idle();
      host_read("t4_absf6", 7, 8'h0A);

      // ADD2B, SHLADD, signed MAX
      ld(1, 8'h10); ld(2, 8'h20);
      issue(3'd6, 3, 1, 2, 0, 1'b0);
      wait_idle();
      host_read("t5_add2b", 3, 8'h50);
      issue(3'd3, 4, 1, 1, 3'd2, 1'b0);
      wait_idle();
      host_read("t5_shladd", 4, 8'h50);
      ld(1, 8'hF0); ld(2, 8'h05);
      issue(3'd2, 6, 1, 2, 0, 1'b0);
      wait_idle();
      host_read("t5_max", 6, 8'h05);

      // Host load on the READ edge: the instruction sees the old operand
      issue(3'd1, 3, 1, 2, 0, 1'b0);
      ld_en = 1'b1; ld_addr = 1; ld_data = 8'h11;
      @(posedge clk); #1;
      ld_en = 1'b0;
      m_regs[1] = 8'h11;
      wait_idle();
      host_read("ld_read_edge_old", 3, 8'hF5);
      host_read("ld_read_edge_new", 1, 8'h11);

      // Host load to rd on the WB edge: writeback wins
      issue(3'd7, 3, 1, 1, 0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      ld_en = 1'b1; ld_addr = 3; ld_data = 8'hEE;
      @(posedge clk); #1;
      ld_en = 1'b0;
      wait_idle();
      host_read("ld_wb_edge", 3, 8'h11);

      // Randomized instructions with occasional host loads
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            wait_idle();
            ld(AW'($urandom_range(0, NREGS - 1)), 8'($urandom_range(0, 255)));
         end
         issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREGS - 1)),
               AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      for (int r = 0; r < NREGS; r++) host_read("rand_regfile", AW'(r), m_regs[r]);

      // Reset while in EXEC aborts the instruction
      issue(3'd1, 2, 1, 1, 0, 1'b0);
      @(posedge clk); #2;
      check("abort_state_exec", 32'(dbg_state), 32'd2);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("abort_flags", 32'(flags), 32'd0);
      check("abort_count", 32'(op_count), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < NREGS; r++) host_read("abort_regfile", AW'(r), 8'h00);
      repeat (4) @(negedge clk);
      check("abort_ready", 32'(instr_ready), 32'd1);

      // instr_valid held through busy cycles: one accept per four cycles
      ld(0, 8'h3C);
      @(negedge clk);
      instr_op = 3'd7; instr_rd = 0; instr_ra = 0; instr_rb = 0;
      instr_n = 0; instr_useci = 1'b0; instr_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         rdy = instr_ready;
         @(posedge clk); #1;
         if (rdy) begin
            acc++;
            model_push(3'd7, 0, 0, 0, 0, 1'b0, cyc);
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("hold_accepts", 32'(acc), 32'd4);
      wait_idle();

      // Run the retired-op counter around to zero
      while (m_count != 0) begin
         issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREGS - 1)),
               AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      @(negedge clk);
      check("count_wrap", 32'(op_count), 32'd0);
      for (int r = 0; r < NREGS; r++) host_read("final_regfile", AW'(r), m_regs[r]);
      check("final_flags", 32'(flags), 32'(m_flags));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
